prime_seq_periph: RTL and testbench
===================================

Name: prime_seq_periph

Overview:
- Parametrised bus-mapped sequential prime-number accelerator with a GPIO side port.
- Software writes an index A; the block iterates candidates and returns W = the A-th prime (2 = 1st).
- Exposes the running prime count, status/control, a completion counter on gpio_out, and an interrupt.
- Sits on the simple srd/swr/saddress slave bus alongside the other emulated GPIO peripherals.

Parameters:
- DATA_W, 32: bus data width.
- ARG_W, 10: width of argument A and prime count S.
- NUM_W, 16: candidate/result width; must satisfy NUM_W <= DATA_W.
- GPIO_W, 16: gpio_in/gpio_out width.
- ADDR_A, 16'h238: argument register (RW).
- ADDR_W, 16'h248: result register (RO).
- ADDR_S, 16'h250: prime count register (RO).
- ADDR_C, 16'h240: control/status register.

Ports:
- clk, in, 1: system clock; all state updates on rising edge.
- n_reset, in, 1: asynchronous, active-low reset.
- saddress, in, 16: register address, valid while srd or swr is high.
- srd, in, 1: read strobe (level); acted on at its rising edge, detected on clk.
- swr, in, 1: write strobe (level); acted on at its rising edge, detected on clk.
- sdata_in, in, DATA_W: write data.
- sdata_out, out, DATA_W: registered read data.
- gpio_in, in, GPIO_W: external inputs.
- gpio_latch, in, 1: latch strobe; rising edge detected on clk.
- gpio_out, out, GPIO_W: completion counter.
- gpio_in_s_insp, out, GPIO_W: latched gpio_in value.
- irq, out, 1: level interrupt = done & irq_en.

Behaviour:
- Reset (async, n_reset=0):
  - Clears sdata_out, gpio_out, gpio_in_s_insp, A, S, W, busy, done, ovf, irq_en and edge-detect flops.
  - FSM goes to IDLE; irq=0.
  - Applies at any time, including mid-computation.
- Strobe handling: srd, swr and gpio_latch each pass through a 2-flop synchroniser plus a previous-value flop; an event is one clk pulse on the rising edge.
- Read:
  - Cycle after the srd event, sdata_out holds the zero-extended register selected by saddress.
  - Unmapped addresses return 0; sdata_out holds its value until the next read.
  - ADDR_C read layout: bit0 busy, bit1 done, bit2 ovf, bit3 irq_en, other bits 0.
- Write ADDR_A:
  - Loads A = sdata_in[ARG_W-1:0] and clears S, W, done and ovf.
  - Sets n=1, busy=1 and moves the FSM to NEXT.
  - A write while busy aborts the current run and restarts; no completion is signalled for the aborted run.
- Write ADDR_C: bit3 sets irq_en; writing 1 to bit1 clears done (W1C); other bits ignored.
- Writes to ADDR_W, ADDR_S or unmapped addresses: ignored.
- Simultaneous srd and swr events: the write takes effect; the read returns the pre-write value.
- gpio_latch event: gpio_in_s_insp <= gpio_in.
- FSM states:
  - IDLE: wait.
  - NEXT: if A==0, go to DONE with W=0. If n == 2^NUM_W-1, go to OVF. Otherwise n<=n+1, d<=2, go to TEST.
  - TEST: if d*d > n (2*NUM_W-bit product), go to FOUND. Else if n % d == 0, go to NEXT. Else d<=d+1 and stay in TEST.
  - FOUND: S<=S+1. If S+1==A, go to DONE; else go to NEXT.
  - DONE: W<=n (0 when A==0); busy<=0, done<=1, gpio_out<=gpio_out+1 (wraps mod 2^GPIO_W); go to IDLE.
  - OVF: W<=0, ovf<=1, busy<=0, done<=1, gpio_out unchanged; go to IDLE.
- Latency for A=1: done=1 and W=2 visible 4 clk after the swr event.
- S is readable mid-run and shows the primes found so far.

Test Plan:
- Reset then read ADDR_A, ADDR_W, ADDR_S, ADDR_C, and 16'h0 -> all 0; gpio_out=0; irq=0.
- Write A=1 -> ADDR_C=0x2 after 4 clk; W=2; S=1; gpio_out=1.
- Write A=10 and poll busy -> W=29 (0x1D), S=10, gpio_out incremented by 1. Then write A=0 -> W=0, S=0, done=1, gpio_out incremented again.
- Set irq_en, write A=5, then write A=3 while busy -> single completion with W=5, irq=1, gpio_out +1 only. Write 0xA to ADDR_C (bit1 W1C, bit3 keeps irq_en) -> done=0, irq=0.
- NUM_W=5 build, write A=12 -> ovf=1, done=1, W=0, S=11, gpio_out unchanged. With A=11 -> W=31.
- Pulse n_reset low mid-run at A=100 -> all registers 0, FSM idle. Then gpio_in=16'hBEEF plus a gpio_latch pulse -> gpio_in_s_insp=16'hBEEF within 3 clk.

Source files
------------

// File: rtl/prime_seq_periph_if.sv
// Slave-bus bundle for the emulated GPIO peripherals: level strobes,
// a 16-bit register address, write data and registered read data.
interface prime_seq_periph_if #(
    parameter int DATA_W = 32
);
    logic [15:0]       saddress;
    logic              srd;
    logic              swr;
    logic [DATA_W-1:0] sdata_in;
    logic [DATA_W-1:0] sdata_out;

    modport master (output saddress, srd, swr, sdata_in, input sdata_out);
    modport slave  (input saddress, srd, swr, sdata_in, output sdata_out);
endinterface

// File: rtl/prime_seq_periph.sv
// Bus-mapped sequential prime accelerator: W = the A-th prime by trial
// division, with a completion counter on gpio_out and a level interrupt.
module prime_seq_periph #(
    parameter int          DATA_W = 32,
    parameter int          ARG_W  = 10,
    parameter int          NUM_W  = 16,
    parameter int          GPIO_W = 16,
    parameter logic [15:0] ADDR_A = 16'h238,
    parameter logic [15:0] ADDR_W = 16'h248,
    parameter logic [15:0] ADDR_S = 16'h250,
    parameter logic [15:0] ADDR_C = 16'h240
) (
    input  logic                clk,
    input  logic                n_reset,
    prime_seq_periph_if.slave   bus,
    input  logic [GPIO_W-1:0]   gpio_in,
    input  logic                gpio_latch,
    output logic [GPIO_W-1:0]   gpio_out,
    output logic [GPIO_W-1:0]   gpio_in_s_insp,
    output logic                irq
);
    typedef enum logic [2:0] {S_IDLE, S_NEXT, S_TEST, S_FOUND, S_DONE, S_OVF} state_e;

    localparam logic [NUM_W-1:0] N_MAX = '1;

    // [0],[1] synchroniser stages, [2] previous value for edge detection
    logic [2:0] srd_sync_q, srd_sync_d;
    logic [2:0] swr_sync_q, swr_sync_d;
    logic [2:0] lat_sync_q, lat_sync_d;

    state_e             state_q, state_d;
    logic [ARG_W-1:0]   a_q, a_d, s_q, s_d;
    logic [NUM_W-1:0]   w_q, w_d, n_q, n_d, d_q, d_d;
    logic               busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic               irq_en_q, irq_en_d;
    logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d, insp_q, insp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d, rd_val;

    logic               rd_ev, wr_ev, lat_ev;
    logic [2*NUM_W-1:0] d_sq;
    logic [NUM_W-1:0]   rem;
    logic [ARG_W-1:0]   s_inc;

    assign rd_ev  = srd_sync_q[1] & ~srd_sync_q[2];
    assign wr_ev  = swr_sync_q[1] & ~swr_sync_q[2];
    assign lat_ev = lat_sync_q[1] & ~lat_sync_q[2];

    // d_q only ever holds 2 or more, so the remainder never divides by zero
    assign d_sq  = d_q * d_q;
    assign rem   = n_q % d_q;
    assign s_inc = s_q + 1'b1;

    always_comb begin
        rd_val = '0;
        case (bus.saddress)
            ADDR_A:  rd_val = DATA_W'(a_q);
            ADDR_W:  rd_val = DATA_W'(w_q);
            ADDR_S:  rd_val = DATA_W'(s_q);
            ADDR_C:  rd_val[3:0] = {irq_en_q, ovf_q, done_q, busy_q};
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        // NOTE: every _d takes its _q value first; any path that skips an
        // assignment then holds state instead of inferring a latch.
        srd_sync_d = {srd_sync_q[1:0], bus.srd};
        swr_sync_d = {swr_sync_q[1:0], bus.swr};
        lat_sync_d = {lat_sync_q[1:0], gpio_latch};
        state_d    = state_q;
        a_d        = a_q;
        s_d        = s_q;
        w_d        = w_q;
        n_d        = n_q;
        d_d        = d_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        irq_en_d   = irq_en_q;
        gpio_out_d = gpio_out_q;
        insp_d     = insp_q;
        rdata_d    = rdata_q;

        if (rd_ev)  rdata_d = rd_val;
        if (lat_ev) insp_d  = gpio_in;

        case (state_q)
            S_IDLE: ;
            S_NEXT: begin
                if (a_q == '0) begin
                    state_d = S_DONE;
                end else if (n_q == N_MAX) begin
                    state_d = S_OVF;
                end else begin
                    n_d     = n_q + 1'b1;
                    d_d     = NUM_W'(2);
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                if (d_sq > {{NUM_W{1'b0}}, n_q}) state_d = S_FOUND;
                else if (rem == '0)             state_d = S_NEXT;
                else                            d_d     = d_q + 1'b1;
            end
            S_FOUND: begin
                s_d     = s_inc;
                state_d = (s_inc == a_q) ? S_DONE : S_NEXT;
            end
            S_DONE: begin
                w_d        = (a_q == '0) ? '0 : n_q;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                gpio_out_d = gpio_out_q + 1'b1;
                state_d    = S_IDLE;
            end
            S_OVF: begin
                w_d     = '0;
                ovf_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes override the FSM step, so a new A aborts a run cleanly
        if (wr_ev) begin
            case (bus.saddress)
                ADDR_A: begin
                    a_d     = bus.sdata_in[ARG_W-1:0];
                    s_d     = '0;
                    w_d     = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    n_d     = NUM_W'(1);
                    busy_d  = 1'b1;
                    state_d = S_NEXT;
                end
                ADDR_C: begin
                    irq_en_d = bus.sdata_in[3];
                    if (bus.sdata_in[1]) done_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            srd_sync_q <= '0;
            swr_sync_q <= '0;
            lat_sync_q <= '0;
            state_q    <= S_IDLE;
            a_q        <= '0;
            s_q        <= '0;
            w_q        <= '0;
            n_q        <= '0;
            d_q        <= NUM_W'(2);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            gpio_out_q <= '0;
            insp_q     <= '0;
            rdata_q    <= '0;
        end else begin
            srd_sync_q <= srd_sync_d;
            swr_sync_q <= swr_sync_d;
            lat_sync_q <= lat_sync_d;
            state_q    <= state_d;
            a_q        <= a_d;
            s_q        <= s_d;
            w_q        <= w_d;
            n_q        <= n_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            gpio_out_q <= gpio_out_d;
            insp_q     <= insp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.sdata_out   = rdata_q;
    assign gpio_out        = gpio_out_q;
    assign gpio_in_s_insp  = insp_q;
    assign irq             = done_q & irq_en_q;
endmodule

// File: tb/tb_prime_seq_periph.sv
// Directed bench for prime_seq_periph: a default build and a NUM_W=5 build
// share one bus; register reads, completions, abort, overflow and reset.
module tb_prime_seq_periph;
    localparam logic [15:0] ADDR_A = 16'h238;
    localparam logic [15:0] ADDR_W = 16'h248;
    localparam logic [15:0] ADDR_S = 16'h250;
    localparam logic [15:0] ADDR_C = 16'h240;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] w;
        logic [31:0] s;
        logic [31:0] c;
    } job_t;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] saddress;
    logic        srd, swr;
    logic [31:0] sdata_in;
    logic [15:0] gpio_in;
    logic        gpio_latch;
    logic [15:0] gpio_out_a, gpio_out_b, insp_a, insp_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_errors = 0;
    int exp_gpio_a = 0;
    int exp_gpio_b = 0;

    always #5 clk = ~clk;

    prime_seq_periph_if #(.DATA_W(32)) bus_a ();
    prime_seq_periph_if #(.DATA_W(32)) bus_b ();

    assign bus_a.saddress = saddress;
    assign bus_a.srd      = srd;
    assign bus_a.swr      = swr;
    assign bus_a.sdata_in = sdata_in;
    assign bus_b.saddress = saddress;
    assign bus_b.srd      = srd;
    assign bus_b.swr      = swr;
    assign bus_b.sdata_in = sdata_in;

    prime_seq_periph dut_a (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus            (bus_a),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out_a),
        .gpio_in_s_insp (insp_a),
        .irq            (irq_a)
    );

    prime_seq_periph #(.NUM_W(5)) dut_b (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus            (bus_b),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out_b),
        .gpio_in_s_insp (insp_b),
        .irq            (irq_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] da, output logic [31:0] db);
        @(negedge clk);
        saddress = addr;
        srd = 1'b1;
        repeat (4) @(negedge clk);
        srd = 1'b0;
        repeat (3) @(negedge clk);
        da = bus_a.sdata_out;
        db = bus_b.sdata_out;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        saddress = addr;
        sdata_in = data;
        swr = 1'b1;
        repeat (4) @(negedge clk);
        swr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Poll the status register of one instance until busy drops
    task automatic wait_idle(input int which, input string name);
        logic [31:0] ra, rb, st;
        logic        ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus_read(ADDR_C, ra, rb);
            st = (which == 0) ? ra : rb;
            if (st[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle_in_budget"}, {31'd0, ok}, 32'd1);
    endtask

    rd_vec_t zero_tab[5];
    job_t    job_tab[3];
    logic [31:0] ra, rb;

    initial begin
        zero_tab[0] = '{ADDR_A, 32'h0};
        zero_tab[1] = '{ADDR_W, 32'h0};
        zero_tab[2] = '{ADDR_S, 32'h0};
        zero_tab[3] = '{ADDR_C, 32'h0};
        zero_tab[4] = '{16'h0000, 32'h0};

        job_tab[0] = '{10'd1,  32'd2,  32'd1,  32'h2};
        job_tab[1] = '{10'd10, 32'h1D, 32'd10, 32'h2};
        job_tab[2] = '{10'd0,  32'd0,  32'd0,  32'h2};

        n_reset = 1'b0;
        saddress = '0;
        srd = 1'b0;
        swr = 1'b0;
        sdata_in = '0;
        gpio_in = '0;
        gpio_latch = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;

        check("reset_gpio_out", 32'(gpio_out_a), 32'h0);
        check("reset_irq", 32'(irq_a), 32'h0);
        for (int i = 0; i < 5; i++) begin
            bus_read(zero_tab[i].addr, ra, rb);
            check($sformatf("reset_rd_%0h", zero_tab[i].addr), ra, zero_tab[i].exp);
        end

        // A=1: completion lands exactly 4 clk after the edge that takes the write
        @(negedge clk);
        saddress = ADDR_A;
        sdata_in = 32'd1;
        swr = 1'b1;
        repeat (6) @(negedge clk);
        check("lat_not_yet", 32'(gpio_out_a), 32'h0);
        @(negedge clk);
        check("lat_done", 32'(gpio_out_a), 32'h1);
        swr = 1'b0;
        repeat (3) @(negedge clk);
        exp_gpio_a++;
        exp_gpio_b++;

        for (int i = 0; i < 3; i++) begin
            bus_write(ADDR_A, 32'(job_tab[i].a));
            wait_idle(0, $sformatf("job%0d", i));
            exp_gpio_a++;
            exp_gpio_b++;
            bus_read(ADDR_W, ra, rb);
            check($sformatf("job%0d_W", i), ra, job_tab[i].w);
            bus_read(ADDR_S, ra, rb);
            check($sformatf("job%0d_S", i), ra, job_tab[i].s);
            bus_read(ADDR_C, ra, rb);
            check($sformatf("job%0d_C", i), ra, job_tab[i].c);
            check($sformatf("job%0d_gpio", i), 32'(gpio_out_a), 32'(exp_gpio_a));
        end

        // Abort: A=5 is replaced by A=3 while busy; one completion, W=5
        bus_write(ADDR_C, 32'h8);
        bus_write(ADDR_A, 32'd5);
        bus_write(ADDR_A, 32'd3);
        wait_idle(0, "abort");
        exp_gpio_a++;
        exp_gpio_b++;
        bus_read(ADDR_W, ra, rb);
        check("abort_W", ra, 32'd5);
        bus_read(ADDR_C, ra, rb);
        check("abort_C", ra, 32'hA);
        check("abort_irq", 32'(irq_a), 32'h1);
        check("abort_gpio", 32'(gpio_out_a), 32'(exp_gpio_a));
        bus_write(ADDR_C, 32'hA);
        bus_read(ADDR_C, ra, rb);
        check("w1c_C", ra, 32'h8);
        check("w1c_irq", 32'(irq_a), 32'h0);

        // NUM_W=5 build: the 12th prime (37) does not fit, 11th (31) does
        bus_write(ADDR_A, 32'd12);
        wait_idle(1, "ovf_b");
        wait_idle(0, "ovf_a");
        exp_gpio_a++;
        bus_read(ADDR_W, ra, rb);
        check("ovf_W", rb, 32'd0);
        check("big_W37", ra, 32'd37);
        bus_read(ADDR_S, ra, rb);
        check("ovf_S", rb, 32'd11);
        bus_read(ADDR_C, ra, rb);
        check("ovf_C", rb, 32'hE);
        check("ovf_gpio", 32'(gpio_out_b), 32'(exp_gpio_b));
        check("ovf_irq", 32'(irq_b), 32'h1);

        bus_write(ADDR_A, 32'd11);
        wait_idle(1, "max_b");
        wait_idle(0, "max_a");
        exp_gpio_a++;
        exp_gpio_b++;
        bus_read(ADDR_W, ra, rb);
        check("max_W", rb, 32'd31);
        check("max_W_big", ra, 32'd31);
        bus_read(ADDR_C, ra, rb);
        check("max_C", rb, 32'hA);
        check("max_gpio", 32'(gpio_out_b), 32'(exp_gpio_b));

        // Asynchronous reset in the middle of a long run (A=100 -> 541)
        bus_write(ADDR_A, 32'd100);
        repeat (50) @(negedge clk);
        bus_read(ADDR_C, ra, rb);
        check("midrun_busy_C", ra, 32'h9);
        #2 n_reset = 1'b0;
        #3 check("rst_async_gpio", 32'(gpio_out_a), 32'h0);
        @(negedge clk);
        n_reset = 1'b1;
        check("rst_irq", 32'(irq_a), 32'h0);
        for (int i = 0; i < 5; i++) begin
            bus_read(zero_tab[i].addr, ra, rb);
            check($sformatf("rst_rd_%0h", zero_tab[i].addr), ra, zero_tab[i].exp);
        end
        repeat (20) @(negedge clk);
        bus_read(ADDR_C, ra, rb);
        check("rst_stays_idle", ra, 32'h0);

        // gpio_latch: captured value visible within 3 clk of the pulse
        @(negedge clk);
        gpio_in = 16'hBEEF;
        gpio_latch = 1'b1;
        @(negedge clk);
        check("latch_not_early", 32'(insp_a), 32'h0);
        gpio_latch = 1'b0;
        repeat (2) @(negedge clk);
        check("latch_val", 32'(insp_a), 32'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
